cdc_chan_arbiter: RTL and testbench
===================================

CDC_CHAN_ARBITER -- requirements
Module: cdc_chan_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of source requesters (2..16).
REQ-002 Parameter DWIDTH, default 32, payload width per requester.
REQ-003 Parameter CNT_W, default 16, width of the transfer counter.
REQ-004 Derived ID_W = max(1, ceil(log2(N_REQ))), the tag width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_data  in  N_REQ x DWIDTH  per-requester payload.
REQ-009 req_vld  in  N_REQ  per-requester valid.
REQ-010 req_rdy  out  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-011 cfg_en  in  N_REQ  requester enable mask; a 0 bit excludes that requester from arbitration.
REQ-012 ch_data  out  ID_W+DWIDTH  {winner id, payload} driven to the shared CDC channel write side.
REQ-013 ch_vld  out  1  channel write valid.
REQ-014 ch_rdy  in  1  channel write ready; may stay low for many cycles during the cross-domain round trip.
REQ-015 xfer_cnt  out  CNT_W  number of words the channel has accepted.

Function
REQ-016 FSM states are IDLE (output register empty) and SEND (output register full, ch_vld=1).
REQ-017 Eligible set: E = req_vld & cfg_en.
REQ-018 Winner: first set bit of E at index ptr, ptr+1, ... wrapping modulo N_REQ.
REQ-019 Load condition: (state==IDLE) or (state==SEND and ch_rdy), and E nonzero.
REQ-020 When the load condition holds, req_rdy[winner]=1 combinationally, ch_data <= {winner, req_data[winner]}, state <= SEND, and ptr <= (winner+1) mod N_REQ.
REQ-021 In SEND with ch_rdy=1 and E=0, state <= IDLE; in SEND with ch_rdy=0, state, ch_data and ptr hold.
REQ-022 ch_vld = (state==SEND); ch_data is stable whenever ch_vld=1 and ch_rdy=0.
REQ-023 Latency: a word accepted at edge T is presented with ch_vld=1 from cycle T+1.
REQ-024 Back-to-back: channel accept and a new load in the same cycle keep ch_vld high with no bubble.
REQ-025 xfer_cnt increments by 1 on every cycle with ch_vld & ch_rdy and wraps at 2^CNT_W-1 -> 0.
REQ-026 Requester behaviour: any req_vld/req_data change without an accept is tolerated; only the accept-cycle value is captured.
REQ-027 cfg_en changes take effect on the next arbitration; a word already loaded is still sent.
REQ-028 If N_REQ is not a power of two, ptr never takes a value >= N_REQ.

Reset
REQ-029 Reset values: state=IDLE, ch_vld=0, ch_data=0, req_rdy=0, ptr=0, xfer_cnt=0.
REQ-030 Reset asserted in SEND discards the held word; req_rdy stays 0 during every reset cycle.

Structure
REQ-031 Shared package cdc_arb_pkg holds the state enum (IDLE, SEND) and the ID-width function.
REQ-032 Round-robin selection sits in one sub-module, rr_arbiter (inputs: E, ptr; outputs: one-hot grant, winner index, any).
REQ-033 Expected size: 120-400 lines of RTL; no memories; no cross-clock logic in this block.

Verification
REQ-034 Fairness: N_REQ=4, all enabled, all req_vld held high, ch_rdy=1 -> ch_data ids 0,1,2,3,0,... one per cycle; xfer_cnt=8 after 8 accepts.
REQ-035 Stall: requester 2 sends 0xDEADBEEF, ch_rdy low for 10 cycles -> ch_vld=1 and ch_data={2,0xDEADBEEF} stable; req_rdy=0 throughout; channel accept on ch_rdy rise.
REQ-036 Mask: cfg_en=4'b1011, all requesting -> id 2 never appears; order 0,1,3,0,...
REQ-037 Idle return: single request from id 1, ch_rdy=1 -> ch_vld high for exactly 1 cycle, then IDLE with ch_vld=0.
REQ-038 Reset mid-SEND: rst high for 1 cycle while ch_vld=1 -> next cycle ch_vld=0, xfer_cnt=0, ptr=0; next grant goes to the lowest requesting index.
REQ-039 Wrap: CNT_W=4, 17 accepts -> xfer_cnt=1.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC channel arbiter: FSM state encoding
// and the requester-tag width calculation.
package cdc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first eligible requester at or after ptr,
// wrapping past the top index back to zero.
module rr_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick;
    logic [ID_W*N-1:0] idx_terms;

    // Bits at or above ptr win first; if none are eligible, fall back to
    // the lowest eligible bit overall, which is the wrapped-around search.
    always_comb begin
        hi_mask = {N{1'b1}} << ptr;
        masked  = elig & hi_mask;
        pick    = (|masked) ? masked : elig;
        grant   = pick & (~pick + N'(1));
        any     = |elig;
    end

    for (genvar gb = 0; gb < ID_W; gb++) begin : g_idx_bit
        for (genvar gi = 0; gi < N; gi++) begin : g_idx_term
            assign idx_terms[gb*N+gi] = (((gi >> gb) & 1) != 0) ? grant[gi] : 1'b0;
        end
        assign idx[gb] = |idx_terms[gb*N +: N];
    end

endmodule

// File: rtl/cdc_chan_arbiter.sv
// Round-robin funnel from N_REQ requesters into a single registered write
// port of a CDC channel, with a running count of accepted words.
module cdc_chan_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 16,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DWIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]        req_vld,
    output logic [N_REQ-1:0]        req_rdy,
    input  logic [N_REQ-1:0]        cfg_en,
    output logic [ID_W+DWIDTH-1:0]  ch_data,
    output logic                    ch_vld,
    input  logic                    ch_rdy,
    output logic [CNT_W-1:0]        xfer_cnt
);

    state_e                   state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [ID_W+DWIDTH-1:0]   ch_data_q, ch_data_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [N_REQ-1:0]         elig;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          win_idx;
    logic                     win_any;
    logic                     load;
    logic [DWIDTH-1:0]        data_chain [N_REQ+1];
    logic [DWIDTH-1:0]        win_data;

    assign elig = req_vld & cfg_en;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .elig  (elig),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // One-hot AND-OR mux of the winning payload.
    assign data_chain[0] = '0;
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data_mux
        assign data_chain[gi+1] = data_chain[gi] |
                                  (grant[gi] ? req_data[gi*DWIDTH +: DWIDTH] : '0);
    end
    assign win_data = data_chain[N_REQ];

    // The output register can take a new word when empty, or when the
    // channel drains it this cycle (back-to-back without a bubble).
    assign load = ((state_q == IDLE) || ch_rdy) && win_any;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ch_data_d = ch_data_q;
        cnt_d     = cnt_q;
        req_rdy   = '0;

        if ((state_q == SEND) && ch_rdy) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
        end

        if (load) begin
            req_rdy   = grant;
            state_d   = SEND;
            ch_data_d = {win_idx, win_data};
            ptr_d     = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end

        if (rst) begin
            req_rdy = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ch_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ch_data_q <= ch_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ch_vld   = (state_q == SEND);
    assign ch_data  = ch_data_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_cdc_chan_arbiter.sv
// Bench for cdc_chan_arbiter: vector table, directed corner sequences and a
// randomized run against a round-robin-by-distance reference model.
module tb_cdc_chan_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 34;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_vld, cfg_en, req_rdy, req_rdy_w;
    logic [CW-1:0] ch_data, ch_data_w;
    logic          ch_vld, ch_vld_w, ch_rdy;
    logic [15:0]   xfer_cnt;
    logic [3:0]    xfer_cnt_w;

    cdc_chan_arbiter #(.N_REQ(N), .DWIDTH(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_vld(req_vld),
        .req_rdy(req_rdy), .cfg_en(cfg_en), .ch_data(ch_data),
        .ch_vld(ch_vld), .ch_rdy(ch_rdy), .xfer_cnt(xfer_cnt)
    );

    cdc_chan_arbiter #(.N_REQ(N), .DWIDTH(DW), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .req_data(req_data), .req_vld(req_vld),
        .req_rdy(req_rdy_w), .cfg_en(cfg_en), .ch_data(ch_data_w),
        .ch_vld(ch_vld_w), .ch_rdy(ch_rdy), .xfer_cnt(xfer_cnt_w)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA000_0000 + DW'(i);
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  en;
        logic        cr;
        logic [3:0]  rdy;
        logic        cv;
        logic [1:0]  id;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] e,
                                input logic c, input logic [3:0] rd, input logic cv,
                                input logic [1:0] id, input logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.vld = v; t.en = e; t.cr = c;
        t.rdy = rd; t.cv = cv; t.id = id; t.cnt = cnt;
        return t;
    endfunction

    vec_t tbl [19];

    // Reference model state: whether a word is held, which word, the
    // round-robin start point and the accept count.
    logic          m_full;
    logic [CW-1:0] m_word;
    int            m_ptr;
    int            m_cnt;

    function automatic int rr_pick(input logic [N-1:0] e, input int start);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (((e >> i) & 4'd1) != 4'd0) begin
                int d = (i - start + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    initial begin
        rst      = 1'b1;
        req_vld  = '0;
        cfg_en   = '0;
        ch_rdy   = 1'b0;
        req_data = {pat(3), pat(2), pat(1), pat(0)};
        @(negedge clk);
        do_reset();

        // Fairness with everyone enabled, then the same with requester 2 masked.
        tbl[0]  = mk(1, 4'hF, 4'hF, 1, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(0, 4'hF, 4'hF, 1, 4'b0001, 0, 0, 0);
        tbl[2]  = mk(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0, 0);
        tbl[3]  = mk(0, 4'hF, 4'hF, 1, 4'b0100, 1, 1, 1);
        tbl[4]  = mk(0, 4'hF, 4'hF, 1, 4'b1000, 1, 2, 2);
        tbl[5]  = mk(0, 4'hF, 4'hF, 1, 4'b0001, 1, 3, 3);
        tbl[6]  = mk(0, 4'hF, 4'hF, 1, 4'b0010, 1, 0, 4);
        tbl[7]  = mk(0, 4'hF, 4'hF, 1, 4'b0100, 1, 1, 5);
        tbl[8]  = mk(0, 4'hF, 4'hF, 1, 4'b1000, 1, 2, 6);
        tbl[9]  = mk(0, 4'h0, 4'hF, 1, 4'b0000, 1, 3, 7);
        tbl[10] = mk(0, 4'h0, 4'hF, 1, 4'b0000, 0, 0, 8);
        tbl[11] = mk(1, 4'h0, 4'hF, 1, 4'b0000, 0, 0, 8);
        tbl[12] = mk(0, 4'hF, 4'hB, 1, 4'b0001, 0, 0, 0);
        tbl[13] = mk(0, 4'hF, 4'hB, 1, 4'b0010, 1, 0, 0);
        tbl[14] = mk(0, 4'hF, 4'hB, 1, 4'b1000, 1, 1, 1);
        tbl[15] = mk(0, 4'hF, 4'hB, 1, 4'b0001, 1, 3, 2);
        tbl[16] = mk(0, 4'hF, 4'hB, 1, 4'b0010, 1, 0, 3);
        tbl[17] = mk(0, 4'h0, 4'hB, 1, 4'b0000, 1, 1, 4);
        tbl[18] = mk(0, 4'h0, 4'hB, 1, 4'b0000, 0, 0, 5);

        for (int i = 0; i < 19; i++) begin
            rst     = tbl[i].rst;
            req_vld = tbl[i].vld;
            cfg_en  = tbl[i].en;
            ch_rdy  = tbl[i].cr;
            #1;
            chk($sformatf("tbl%0d_req_rdy", i), 64'(req_rdy), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ch_vld", i), 64'(ch_vld), 64'(tbl[i].cv));
            if (tbl[i].cv)
                chk($sformatf("tbl%0d_ch_data", i), 64'(ch_data), 64'({tbl[i].id, pat(int'(tbl[i].id))}));
            chk($sformatf("tbl%0d_xfer_cnt", i), 64'(xfer_cnt), 64'(tbl[i].cnt));
            $display("vec %0d rst=%0b vld=%h en=%h cr=%0b rdy=%h ch_vld=%0b ch_data=%h cnt=%0d",
                     i, rst, req_vld, cfg_en, ch_rdy, req_rdy, ch_vld, ch_data, xfer_cnt);
            tick();
        end
        rst = 1'b0;

        // Long stall: held word stays put while requester data churns.
        do_reset();
        cfg_en   = 4'hF;
        req_vld  = 4'b0100;
        ch_rdy   = 1'b0;
        req_data = {pat(3), 32'hDEADBEEF, pat(1), pat(0)};
        #1 chk("stall_accept_rdy", 64'(req_rdy), 64'(4'b0100));
        tick();
        req_data = {pat(3), 32'h1234_5678, pat(1), pat(0)};
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("stall%0d_vld", k), 64'(ch_vld), 64'd1);
            chk($sformatf("stall%0d_data", k), 64'(ch_data), 64'({2'd2, 32'hDEADBEEF}));
            chk($sformatf("stall%0d_rdy", k), 64'(req_rdy), 64'd0);
            $display("stall cycle %0d ch_vld=%0b ch_data=%h req_rdy=%h", k, ch_vld, ch_data, req_rdy);
            tick();
        end
        req_vld = 4'b0000;
        ch_rdy  = 1'b1;
        #1;
        chk("stall_release_vld", 64'(ch_vld), 64'd1);
        chk("stall_release_cnt", 64'(xfer_cnt), 64'd0);
        tick();
        #1;
        chk("stall_after_vld", 64'(ch_vld), 64'd0);
        chk("stall_after_cnt", 64'(xfer_cnt), 64'd1);
        $display("stall release ch_vld=%0b cnt=%0d", ch_vld, xfer_cnt);

        // Single request returns to IDLE after one valid cycle.
        do_reset();
        req_data = {pat(3), pat(2), pat(1), pat(0)};
        req_vld  = 4'b0010;
        ch_rdy   = 1'b1;
        #1 chk("idle_rdy", 64'(req_rdy), 64'(4'b0010));
        tick();
        req_vld = 4'b0000;
        #1;
        chk("idle_vld1", 64'(ch_vld), 64'd1);
        chk("idle_data", 64'(ch_data), 64'({2'd1, pat(1)}));
        tick();
        #1 chk("idle_vld0", 64'(ch_vld), 64'd0);
        tick();
        #1;
        chk("idle_vld0b", 64'(ch_vld), 64'd0);
        chk("idle_cnt", 64'(xfer_cnt), 64'd1);
        $display("idle return ch_vld=%0b cnt=%0d", ch_vld, xfer_cnt);

        // Reset while a word is held; pointer must return to zero.
        do_reset();
        req_vld = 4'hF;
        ch_rdy  = 1'b1;
        tick();
        tick();
        #1 chk("rst_pre_vld", 64'(ch_vld), 64'd1);
        rst = 1'b1;
        #1 chk("rst_during_rdy", 64'(req_rdy), 64'd0);
        tick();
        rst     = 1'b0;
        req_vld = 4'b1110;
        #1;
        chk("rst_post_vld", 64'(ch_vld), 64'd0);
        chk("rst_post_cnt", 64'(xfer_cnt), 64'd0);
        chk("rst_post_data", 64'(ch_data), 64'd0);
        chk("rst_post_rdy", 64'(req_rdy), 64'(4'b0010));
        $display("reset mid-send ch_vld=%0b cnt=%0d req_rdy=%h", ch_vld, xfer_cnt, req_rdy);

        // Counter wrap on the 4-bit instance: 17 accepts.
        do_reset();
        req_vld = 4'hF;
        ch_rdy  = 1'b1;
        repeat (18) tick();
        #1;
        chk("wrap_cnt4", 64'(xfer_cnt_w), 64'd1);
        chk("wrap_cnt16", 64'(xfer_cnt), 64'd17);
        $display("wrap cnt4=%0d cnt16=%0d", xfer_cnt_w, xfer_cnt);

        // Randomized run against the reference model.
        do_reset();
        m_full = 1'b0;
        m_word = '0;
        m_ptr  = 0;
        m_cnt  = 0;
        cfg_en = 4'hF;
        for (int c = 0; c < 800; c++) begin
            int            win;
            logic [N-1:0]  exp_rdy;
            logic          can_take;
            logic [DW-1:0] wd;
            rst      = ($urandom_range(0, 59) == 0);
            req_vld  = 4'($urandom);
            if ($urandom_range(0, 9) == 0) cfg_en = 4'($urandom);
            ch_rdy   = (($urandom_range(0, 3) != 0) || (c % 40 < 8)) && (c % 40 >= 4);
            req_data = {$urandom, $urandom, $urandom, $urandom};

            win      = rr_pick(req_vld & cfg_en, m_ptr);
            can_take = (!m_full || ch_rdy) && (win >= 0) && !rst;
            exp_rdy  = can_take ? (4'd1 << win) : 4'd0;
            #1;
            chk($sformatf("rnd%0d_req_rdy", c), 64'(req_rdy), 64'(exp_rdy));
            chk($sformatf("rnd%0d_ch_vld", c), 64'(ch_vld), 64'(m_full));
            chk($sformatf("rnd%0d_ch_data", c), 64'(ch_data), 64'(m_word));
            chk($sformatf("rnd%0d_cnt", c), 64'(xfer_cnt), 64'(m_cnt % 65536));
            chk($sformatf("rnd%0d_cnt4", c), 64'(xfer_cnt_w), 64'(m_cnt % 16));
            $display("rnd %0d rst=%0b vld=%h en=%h cr=%0b rdy=%h ch_vld=%0b ch_data=%h cnt=%0d",
                     c, rst, req_vld, cfg_en, ch_rdy, req_rdy, ch_vld, ch_data, xfer_cnt);
            tick();

            if (rst) begin
                m_full = 1'b0;
                m_word = '0;
                m_ptr  = 0;
                m_cnt  = 0;
            end else begin
                if (m_full && ch_rdy) begin
                    m_cnt++;
                    m_full = 1'b0;
                end
                if (can_take) begin
                    wd     = DW'(req_data >> (win * DW));
                    m_full = 1'b1;
                    m_word = {2'(win), wd};
                    m_ptr  = (win + 1) % N;
                end
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
